// File: rtl/prefix_decoder.sv
// x86-style instruction prefix decoder: folds segment/REP/LOCK prefix bytes into
// an accumulator and presents each opcode together with its prefix set to decode.
module prefix_decoder (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       byte_valid,
    input  logic [7:0] byte_in,
    output logic       byte_ready,
    output logic       opcode_valid,
    input  logic       opcode_ready,
    output logic [7:0] opcode,
    output logic       seg_override,
    output logic [1:0] seg_sel,
    output logic       rep,
    output logic       rep_z,
    output logic       lock,
    output logic [3:0] prefix_count
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PREFIX = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    logic [1:0] state_q, state_d;

    logic       acc_seg_ov_q, acc_seg_ov_d;
    logic [1:0] acc_seg_sel_q, acc_seg_sel_d;
    logic       acc_rep_q, acc_rep_d;
    logic       acc_rep_z_q, acc_rep_z_d;
    logic       acc_lock_q, acc_lock_d;
    logic [3:0] acc_count_q, acc_count_d;

    logic       out_valid_q, out_valid_d;
    logic [7:0] out_opcode_q, out_opcode_d;
    logic       out_seg_ov_q, out_seg_ov_d;
    logic [1:0] out_seg_sel_q, out_seg_sel_d;
    logic       out_rep_q, out_rep_d;
    logic       out_rep_z_q, out_rep_z_d;
    logic       out_lock_q, out_lock_d;
    logic [3:0] out_count_q, out_count_d;

    logic is_prefix;
    logic pfx_seg;
    logic pfx_rep;
    logic pfx_lock;
    logic byte_xfer;
    logic retire;

    always_comb begin
        is_prefix = 1'b1;
        pfx_seg   = 1'b0;
        pfx_rep   = 1'b0;
        pfx_lock  = 1'b0;
        case (byte_in)
            8'h26, 8'h2E, 8'h36, 8'h3E: pfx_seg  = 1'b1;
            8'hF0:                      pfx_lock = 1'b1;
            8'hF2, 8'hF3:               pfx_rep  = 1'b1;
            default:                    is_prefix = 1'b0;
        endcase
    end

    assign byte_ready = !flush && (state_q != ST_HOLD || opcode_ready);
    assign byte_xfer  = byte_valid && byte_ready;
    assign retire     = (state_q == ST_HOLD) && opcode_ready;

    // Retire happens before the new byte is applied so a same-cycle opcode
    // overwrites the output register without a bubble.
    always_comb begin
        state_d       = state_q;
        acc_seg_ov_d  = acc_seg_ov_q;
        acc_seg_sel_d = acc_seg_sel_q;
        acc_rep_d     = acc_rep_q;
        acc_rep_z_d   = acc_rep_z_q;
        acc_lock_d    = acc_lock_q;
        acc_count_d   = acc_count_q;
        out_valid_d   = out_valid_q;
        out_opcode_d  = out_opcode_q;
        out_seg_ov_d  = out_seg_ov_q;
        out_seg_sel_d = out_seg_sel_q;
        out_rep_d     = out_rep_q;
        out_rep_z_d   = out_rep_z_q;
        out_lock_d    = out_lock_q;
        out_count_d   = out_count_q;

        if (flush || retire) begin
            state_d       = ST_IDLE;
            out_valid_d   = 1'b0;
            out_opcode_d  = 8'h00;
            out_seg_ov_d  = 1'b0;
            out_seg_sel_d = 2'b00;
            out_rep_d     = 1'b0;
            out_rep_z_d   = 1'b0;
            out_lock_d    = 1'b0;
            out_count_d   = 4'd0;
        end

        if (flush) begin
            acc_seg_ov_d  = 1'b0;
            acc_seg_sel_d = 2'b00;
            acc_rep_d     = 1'b0;
            acc_rep_z_d   = 1'b0;
            acc_lock_d    = 1'b0;
            acc_count_d   = 4'd0;
        end else if (byte_xfer) begin
            if (is_prefix) begin
                state_d = ST_PREFIX;
                if (pfx_seg) begin
                    acc_seg_ov_d  = 1'b1;
                    acc_seg_sel_d = byte_in[4:3];
                end
                if (pfx_rep) begin
                    acc_rep_d   = 1'b1;
                    acc_rep_z_d = byte_in[0];
                end
                if (pfx_lock) begin
                    acc_lock_d = 1'b1;
                end
                acc_count_d = (acc_count_q == 4'd15) ? 4'd15 : acc_count_q + 4'd1;
            end else begin
                state_d       = ST_HOLD;
                out_valid_d   = 1'b1;
                out_opcode_d  = byte_in;
                out_seg_ov_d  = acc_seg_ov_q;
                out_seg_sel_d = acc_seg_sel_q;
                out_rep_d     = acc_rep_q;
                out_rep_z_d   = acc_rep_z_q;
                out_lock_d    = acc_lock_q;
                out_count_d   = acc_count_q;
                acc_seg_ov_d  = 1'b0;
                acc_seg_sel_d = 2'b00;
                acc_rep_d     = 1'b0;
                acc_rep_z_d   = 1'b0;
                acc_lock_d    = 1'b0;
                acc_count_d   = 4'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            acc_seg_ov_q  <= 1'b0;
            acc_seg_sel_q <= 2'b00;
            acc_rep_q     <= 1'b0;
            acc_rep_z_q   <= 1'b0;
            acc_lock_q    <= 1'b0;
            acc_count_q   <= 4'd0;
            out_valid_q   <= 1'b0;
            out_opcode_q  <= 8'h00;
            out_seg_ov_q  <= 1'b0;
            out_seg_sel_q <= 2'b00;
            out_rep_q     <= 1'b0;
            out_rep_z_q   <= 1'b0;
            out_lock_q    <= 1'b0;
            out_count_q   <= 4'd0;
        end else begin
            state_q       <= state_d;
            acc_seg_ov_q  <= acc_seg_ov_d;
            acc_seg_sel_q <= acc_seg_sel_d;
            acc_rep_q     <= acc_rep_d;
            acc_rep_z_q   <= acc_rep_z_d;
            acc_lock_q    <= acc_lock_d;
            acc_count_q   <= acc_count_d;
            out_valid_q   <= out_valid_d;
            out_opcode_q  <= out_opcode_d;
            out_seg_ov_q  <= out_seg_ov_d;
            out_seg_sel_q <= out_seg_sel_d;
            out_rep_q     <= out_rep_d;
            out_rep_z_q   <= out_rep_z_d;
            out_lock_q    <= out_lock_d;
            out_count_q   <= out_count_d;
        end
    end

    assign opcode_valid = out_valid_q;
    assign opcode       = out_opcode_q;
    assign seg_override = out_seg_ov_q;
    assign seg_sel      = out_seg_sel_q;
    assign rep          = out_rep_q;
    assign rep_z        = out_rep_z_q;
    assign lock         = out_lock_q;
    assign prefix_count = out_count_q;

endmodule

// File: tb/tb_prefix_decoder.sv
// Self-checking bench for prefix_decoder: fixed vector table, hand-written corner
// sequences and randomized traffic against a prefix-history reference model.
module tb_prefix_decoder;

    logic       clk;
    logic       reset;
    logic       flush;
    logic       byte_valid;
    logic [7:0] byte_in;
    logic       byte_ready;
    logic       opcode_valid;
    logic       opcode_ready;
    logic [7:0] opcode;
    logic       seg_override;
    logic [1:0] seg_sel;
    logic       rep;
    logic       rep_z;
    logic       lock;
    logic [3:0] prefix_count;

    prefix_decoder dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .byte_valid   (byte_valid),
        .byte_in      (byte_in),
        .byte_ready   (byte_ready),
        .opcode_valid (opcode_valid),
        .opcode_ready (opcode_ready),
        .opcode       (opcode),
        .seg_override (seg_override),
        .seg_sel      (seg_sel),
        .rep          (rep),
        .rep_z        (rep_z),
        .lock         (lock),
        .prefix_count (prefix_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flush_i;
        logic        valid_i;
        logic [7:0]  byte_i;
        logic        ready_i;
        logic        br_e;
        logic [31:0] out_e;
    } vec_t;

    vec_t tbl[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the raw list of prefix bytes since the last opcode,
    // resolved into a prefix set only when an opcode arrives.
    logic [7:0]  pend[$];
    logic        m_hold;
    logic [31:0] m_out;

    function automatic logic [31:0] pack_out(input logic v, input logic [7:0] op,
                                             input logic sov, input logic [1:0] ssel,
                                             input logic rp, input logic rpz,
                                             input logic lk, input logic [3:0] cnt);
        return {13'd0, v, op, sov, ssel, rp, rpz, lk, cnt};
    endfunction

    function automatic logic [31:0] dut_vec();
        return pack_out(opcode_valid, opcode, seg_override, seg_sel, rep, rep_z, lock, prefix_count);
    endfunction

    function automatic logic is_pfx(input logic [7:0] b);
        return (b == 8'h26) || (b == 8'h2E) || (b == 8'h36) || (b == 8'h3E) ||
               (b == 8'hF0) || (b == 8'hF2) || (b == 8'hF3);
    endfunction

    task automatic model_reset();
        pend.delete();
        m_hold = 1'b0;
        m_out  = 32'd0;
    endtask

    task automatic model_update(input logic f, input logic v, input logic [7:0] b, input logic r);
        logic       xfer;
        logic       sov;
        logic [1:0] ssel;
        logic       rp;
        logic       rpz;
        logic       lk;
        logic [3:0] cnt;
        if (f) begin
            model_reset();
        end else begin
            xfer = v && (!m_hold || r);
            if (m_hold && r) begin
                m_hold = 1'b0;
                m_out  = 32'd0;
            end
            if (xfer) begin
                if (is_pfx(b)) begin
                    pend.push_back(b);
                end else begin
                    sov = 1'b0; ssel = 2'b00; rp = 1'b0; rpz = 1'b0; lk = 1'b0;
                    foreach (pend[i]) begin
                        case (pend[i])
                            8'h26: begin sov = 1'b1; ssel = 2'b00; end
                            8'h2E: begin sov = 1'b1; ssel = 2'b01; end
                            8'h36: begin sov = 1'b1; ssel = 2'b10; end
                            8'h3E: begin sov = 1'b1; ssel = 2'b11; end
                            8'hF0: lk = 1'b1;
                            8'hF2: begin rp = 1'b1; rpz = 1'b0; end
                            8'hF3: begin rp = 1'b1; rpz = 1'b1; end
                            default: ;
                        endcase
                    end
                    cnt    = (pend.size() > 15) ? 4'd15 : 4'(pend.size());
                    m_out  = pack_out(1'b1, b, sov, ssel, rp, rpz, lk, cnt);
                    m_hold = 1'b1;
                    pend.delete();
                end
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // One clock: drive at the falling edge, check byte_ready combinationally,
    // then check registered outputs just after the rising edge.
    task automatic applyStimulus(input logic f, input logic v, input logic [7:0] b,
                                 input logic r, output logic br_seen);
        @(negedge clk);
        flush = f; byte_valid = v; byte_in = b; opcode_ready = r;
        #1;
        br_seen = byte_ready;
        checkOutput("byte_ready", {31'd0, byte_ready}, {31'd0, !f && (!m_hold || r)});
        model_update(f, v, b, r);
        @(posedge clk);
        #1;
        checkOutput("outputs", dut_vec(), m_out);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3;
        reset = 1'b1; flush = 1'b0; byte_valid = 1'b0; opcode_ready = 1'b0;
        #1;
        model_reset();
        checkOutput("reset_async_outputs", dut_vec(), 32'd0);
        checkOutput("reset_byte_ready", {31'd0, byte_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic add_vec(input logic f, input logic v, input logic [7:0] b, input logic r,
                           input logic br, input logic [31:0] out);
        vec_t e;
        e.flush_i = f; e.valid_i = v; e.byte_i = b; e.ready_i = r; e.br_e = br; e.out_e = out;
        tbl.push_back(e);
    endtask

    logic        br;
    logic [31:0] rnd;
    logic [7:0]  pfx_list[7];

    initial begin
        pfx_list = '{8'h26, 8'h2E, 8'h36, 8'h3E, 8'hF0, 8'hF2, 8'hF3};
        reset = 1'b1; flush = 1'b0; byte_valid = 1'b0; byte_in = 8'h00; opcode_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("reset_state", dut_vec(), 32'd0);
        checkOutput("reset_byte_ready", {31'd0, byte_ready}, 32'd1);

        // 2E,8B: CS override with one prefix
        add_vec(1'b0, 1'b1, 8'h2E, 1'b1, 1'b1, 32'd0);
        add_vec(1'b0, 1'b1, 8'h8B, 1'b1, 1'b1, pack_out(1'b1, 8'h8B, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 4'd1));
        add_vec(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'd0);
        // 26,36,F2,F3,F0,A4: last segment and last rep win, lock sticky
        add_vec(1'b0, 1'b1, 8'h26, 1'b1, 1'b1, 32'd0);
        add_vec(1'b0, 1'b1, 8'h36, 1'b1, 1'b1, 32'd0);
        add_vec(1'b0, 1'b1, 8'hF2, 1'b1, 1'b1, 32'd0);
        add_vec(1'b0, 1'b1, 8'hF3, 1'b1, 1'b1, 32'd0);
        add_vec(1'b0, 1'b1, 8'hF0, 1'b1, 1'b1, 32'd0);
        add_vec(1'b0, 1'b1, 8'hA4, 1'b1, 1'b1, pack_out(1'b1, 8'hA4, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 4'd5));
        add_vec(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, pack_out(1'b1, 8'hA4, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 4'd5));
        // back-to-back opcode replaces held one with no bubble
        add_vec(1'b0, 1'b1, 8'h90, 1'b1, 1'b1, pack_out(1'b1, 8'h90, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0));
        add_vec(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'd0);
        // 3E, flush (byte not consumed), 8A
        add_vec(1'b0, 1'b1, 8'h3E, 1'b0, 1'b1, 32'd0);
        add_vec(1'b1, 1'b1, 8'h8A, 1'b0, 1'b0, 32'd0);
        add_vec(1'b0, 1'b1, 8'h8A, 1'b0, 1'b1, pack_out(1'b1, 8'h8A, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0));
        add_vec(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'd0);
        // opcode_ready with nothing presented is ignored
        add_vec(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'd0);

        foreach (tbl[i]) begin
            applyStimulus(tbl[i].flush_i, tbl[i].valid_i, tbl[i].byte_i, tbl[i].ready_i, br);
            checkOutput($sformatf("tbl%0d_byte_ready", i), {31'd0, br}, {31'd0, tbl[i].br_e});
            checkOutput($sformatf("tbl%0d_outputs", i), dut_vec(), tbl[i].out_e);
        end

        // Backpressure: 90 held while 3E waits, then accepted on retire
        applyStimulus(1'b0, 1'b1, 8'h90, 1'b0, br);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 8'h3E, 1'b0, br);
            checkOutput("hold_byte_ready", {31'd0, br}, 32'd0);
            checkOutput("hold_opcode", dut_vec(), pack_out(1'b1, 8'h90, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0));
        end
        applyStimulus(1'b0, 1'b1, 8'h3E, 1'b1, br);
        checkOutput("retire_accept", {31'd0, br}, 32'd1);
        checkOutput("retire_valid", {31'd0, opcode_valid}, 32'd0);
        applyStimulus(1'b0, 1'b1, 8'h01, 1'b1, br);
        checkOutput("after_hold_ds", dut_vec(), pack_out(1'b1, 8'h01, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 4'd1));
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, br);

        // Prefix count saturation
        for (int k = 0; k < 16; k++) applyStimulus(1'b0, 1'b1, 8'h26, 1'b1, br);
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b1, br);
        checkOutput("sat_count", dut_vec(), pack_out(1'b1, 8'h00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 4'd15));
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, br);

        // Reset mid-prefix discards F3
        applyStimulus(1'b0, 1'b1, 8'hF3, 1'b0, br);
        pulse_reset();
        applyStimulus(1'b0, 1'b1, 8'h6C, 1'b0, br);
        checkOutput("post_reset_6c", dut_vec(), pack_out(1'b1, 8'h6C, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0));
        // Reset while holding an opcode
        pulse_reset();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, br);

        // Randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            logic       f;
            logic       v;
            logic       r;
            logic [7:0] b;
            f = ($urandom_range(0, 15) == 0);
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 1) == 1);
            rnd = $urandom();
            if (rnd[8]) b = pfx_list[$urandom_range(0, 6)];
            else        b = rnd[7:0];
            applyStimulus(f, v, b, r, br);
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, br);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/prefix_decoder.md
PREFIX_DECODER -- requirements
Module: prefix_decoder

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 flush  input  1  synchronous discard of all prefix and opcode state (branch, interrupt, queue flush).
REQ-004 byte_valid  input  1  instruction byte available from prefetch queue.
REQ-005 byte_in  input  8  instruction byte.
REQ-006 byte_ready  output  1  byte accepted this cycle when high with byte_valid.
REQ-007 opcode_valid  output  1  registered opcode plus prefix set presented to decode.
REQ-008 opcode_ready  input  1  decode consumes the presented opcode.
REQ-009 opcode  output  8  first non-prefix byte.
REQ-010 seg_override  output  1  a segment override prefix applies to opcode; drives segment-override logic.
REQ-011 seg_sel  output  2  overriding segment: ES=00, CS=01, SS=10, DS=11.
REQ-012 rep  output  1  REP/REPE/REPNE prefix applies.
REQ-013 rep_z  output  1  1 = F3 (REP/REPE), 0 = F2 (REPNE); meaningful only with rep.
REQ-014 lock  output  1  LOCK (F0) prefix applies.
REQ-015 prefix_count  output  4  number of prefix bytes preceding opcode, saturating at 15.

Function
REQ-016 Prefix bytes: 26h->ES, 2Eh->CS, 36h->SS, 3Eh->DS, F0h->LOCK, F2h->REPNE, F3h->REP; every other value is an opcode.
REQ-017 States: IDLE (no prefix pending, output empty), PREFIX (at least one prefix accumulated, output empty), HOLD (opcode_valid high).
REQ-018 byte_ready = !flush && (state != HOLD || opcode_ready); combinational.
REQ-019 Byte transfer occurs when byte_valid && byte_ready.
REQ-020 Prefix transfer: update accumulator, increment count (saturate at 15), go to PREFIX; no output change.
REQ-021 Opcode transfer: register opcode with the accumulated seg/rep/lock/count, opcode_valid=1, clear accumulator, go to HOLD.
REQ-022 Latency: opcode accepted in cycle N -> opcode_valid and all prefix outputs valid in cycle N+1; zero bubbles between back-to-back instructions.
REQ-023 HOLD: opcode and prefix outputs held stable until opcode_ready; opcode_ready without a byte transfer -> IDLE.
REQ-024 HOLD with opcode_ready and a byte transfer in the same cycle: retire the current opcode; the new byte is handled per REQ-020/021 (prefix -> PREFIX, opcode -> HOLD with new data).
REQ-025 Repeated segment prefixes: the last one wins. F2 and F3 both present: the last one wins. LOCK is sticky until opcode.
REQ-026 Prefix outputs are 0 whenever opcode_valid is 0.
REQ-027 flush has priority over all transfers: accumulator, count and output register cleared, state IDLE next cycle, no byte consumed during the flush cycle.
REQ-028 opcode_ready while opcode_valid is 0 is ignored.

Reset
REQ-029 reset asserted at any time, including mid-prefix or in HOLD: state IDLE; opcode_valid, opcode, seg_override, seg_sel, rep, rep_z, lock, prefix_count all 0; byte_ready follows REQ-018 (1 after reset when flush is 0).
REQ-030 A partially accumulated prefix set is discarded by reset and never reaches the output.

Verification
REQ-031 Bytes 2Eh, 8Bh with opcode_ready=1 -> one cycle after 8Bh: opcode=8Bh, seg_override=1, seg_sel=01, prefix_count=1, rep=0, lock=0.
REQ-032 Bytes 26h, 36h, F2h, F3h, F0h, A4h -> opcode=A4h, seg_sel=10, rep=1, rep_z=1, lock=1, prefix_count=5.
REQ-033 Opcode 90h held with opcode_ready=0 for 3 cycles while byte_valid=1 -> byte_ready=0, outputs stable; on opcode_ready=1 the next byte 3Eh is accepted the same cycle and opcode_valid=0 the following cycle.
REQ-034 Bytes 3Eh, then flush, then 8Ah -> opcode=8Ah, seg_override=0, prefix_count=0; no byte consumed during the flush cycle.
REQ-035 Sixteen 26h bytes then 00h -> prefix_count=15, seg_sel=00, opcode=00h.
REQ-036 reset pulsed while in PREFIX after F3h -> all outputs 0; next opcode 6Ch is presented with rep=0, prefix_count=0.
